// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the PC, fetches over a req/ack memory port, presents one held instruction to decode.
// FETCH->HOLD one cycle after ack; HOLD->FETCH one cycle after Advance; misaligned redirect traps into sticky FAULT.
module instr_fetch_unit #(
  parameter int                 width    = 32,
  parameter logic [width-1:0]   RESET_PC = '0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             PCSrc,
  input  logic [width-1:0] PCTarget,
  input  logic             Advance,
  output logic             IMemReq,
  output logic [width-1:0] IMemAddr,
  input  logic             IMemAck,
  input  logic [width-1:0] IMemRData,
  output logic [width-1:0] Instr,
  output logic             InstrValid,
  output logic [width-1:0] PC,
  output logic [width-1:0] PCPlus4,
  output logic             Fault,
  output logic [width-1:0] RetireCount
);

  localparam logic [width-1:0] NOP = width'(32'h0000_0013);

  typedef enum logic [1:0] {FETCH, HOLD, FAULT} state_t;

  state_t           state;
  logic [width-1:0] next_pc;

  assign PCPlus4  = PC + width'(4);
  assign next_pc  = PCSrc ? PCTarget : PCPlus4;
  assign IMemAddr = PC;
  // Gated by RST so the request drops the instant reset asserts, and rises right after release.
  assign IMemReq  = RST && (state == FETCH);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= FETCH;
      PC          <= RESET_PC;
      Instr       <= NOP;
      InstrValid  <= 1'b0;
      Fault       <= 1'b0;
      RetireCount <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (IMemAck) begin
            Instr      <= IMemRData;
            InstrValid <= 1'b1;
            state      <= HOLD;
          end
        end
        HOLD: begin
          if (Advance) begin
            RetireCount <= RetireCount + width'(1);
            InstrValid  <= 1'b0;
            if (next_pc[1:0] == 2'b00) begin
              PC    <= next_pc;
              state <= FETCH;
            end else begin
              Fault <= 1'b1;
              state <= FAULT;
            end
          end
        end
        default: begin
          InstrValid <= 1'b0;
          Fault      <= 1'b1;
          state      <= FAULT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: variable-latency memory model with a fetch scoreboard plus a redirect vector table.
module tb_instr_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        PCSrc = 1'b0;
  logic [31:0] PCTarget = '0;
  logic        Advance = 1'b0;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemAck = 1'b0;
  logic [31:0] IMemRData = '0;
  logic [31:0] Instr;
  logic        InstrValid;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        Fault;
  logic [31:0] RetireCount;

  int checks   = 0;
  int failures = 0;

  int mem_wait = 0;
  bit junk_ack = 1'b0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } fetch_t;
  fetch_t sb[$];

  typedef struct {
    logic [31:0] pc;
    int          wait_cyc;
    int          hold;
    logic        pcsrc;
    logic [31:0] tgt;
    logic [31:0] exp_next;
    logic        exp_fault;
  } vec_t;
  vec_t tbl[7];

  int          cnt = 0;
  logic        prev_valid = 1'b0;
  logic [31:0] req_addr = '0;
  int          exp_retire = 0;

  always #5 CLK = ~CLK;

  instr_fetch_unit #(.width(32), .RESET_PC(RST_PC)) dut (
    .CLK(CLK), .RST(RST), .PCSrc(PCSrc), .PCTarget(PCTarget), .Advance(Advance),
    .IMemReq(IMemReq), .IMemAddr(IMemAddr), .IMemAck(IMemAck), .IMemRData(IMemRData),
    .Instr(Instr), .InstrValid(InstrValid), .PC(PC), .PCPlus4(PCPlus4),
    .Fault(Fault), .RetireCount(RetireCount)
  );

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory model and scoreboard, both evaluated on the falling edge.
  always @(negedge CLK) begin
    if (!RST) begin
      IMemAck    = 1'b0;
      cnt        = 0;
      prev_valid = 1'b0;
      sb.delete();
    end else begin
      if (InstrValid && !prev_valid) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_valid", 32'd1, 32'd0);
        end else begin
          fetch_t e;
          e = sb.pop_front();
          chk("sb_instr", Instr, e.data);
          chk("sb_pc", PC, e.addr);
        end
      end
      prev_valid = InstrValid;
      if (IMemReq) begin
        if (cnt > 0) chk("req_addr_stable", IMemAddr, req_addr);
        else req_addr = IMemAddr;
        if (cnt == mem_wait) begin
          IMemAck   = 1'b1;
          IMemRData = mem_data(IMemAddr);
          sb.push_back('{addr: IMemAddr, data: mem_data(IMemAddr)});
          cnt = 0;
        end else begin
          IMemAck   = 1'b0;
          IMemRData = 32'hDEAD_BEEF;
          cnt++;
        end
      end else begin
        IMemAck   = junk_ack;
        IMemRData = $urandom;
        cnt       = 0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [31:0] held;

    tbl[0] = '{pc: 32'h10,       wait_cyc: 3, hold: 0, pcsrc: 1'b1, tgt: 32'h20,       exp_next: 32'h20,       exp_fault: 1'b0};
    tbl[1] = '{pc: 32'h20,       wait_cyc: 0, hold: 5, pcsrc: 1'b1, tgt: 32'h100,      exp_next: 32'h100,      exp_fault: 1'b0};
    tbl[2] = '{pc: 32'h100,      wait_cyc: 1, hold: 1, pcsrc: 1'b0, tgt: 32'h55,       exp_next: 32'h104,      exp_fault: 1'b0};
    tbl[3] = '{pc: 32'h104,      wait_cyc: 2, hold: 0, pcsrc: 1'b1, tgt: 32'hFFFFFFFC, exp_next: 32'hFFFFFFFC, exp_fault: 1'b0};
    tbl[4] = '{pc: 32'hFFFFFFFC, wait_cyc: 0, hold: 0, pcsrc: 1'b0, tgt: 32'h3,        exp_next: 32'h0,        exp_fault: 1'b0};
    tbl[5] = '{pc: 32'h0,        wait_cyc: 1, hold: 0, pcsrc: 1'b1, tgt: 32'h40,       exp_next: 32'h40,       exp_fault: 1'b0};
    tbl[6] = '{pc: 32'h40,       wait_cyc: 0, hold: 1, pcsrc: 1'b1, tgt: 32'h102,      exp_next: 32'h40,       exp_fault: 1'b1};

    // Reset values
    #22;
    chk("rst_req", {31'd0, IMemReq}, 32'd0);
    chk("rst_pc", PC, RST_PC);
    chk("rst_instr", Instr, NOP);
    chk("rst_valid", {31'd0, InstrValid}, 32'd0);
    chk("rst_fault", {31'd0, Fault}, 32'd0);
    chk("rst_retire", RetireCount, 32'd0);

    @(negedge CLK); #2 RST = 1'b1;
    Advance = 1'b1; PCSrc = 1'b0; mem_wait = 0;
    #1;
    chk("first_req", {31'd0, IMemReq}, 32'd1);
    chk("first_addr", IMemAddr, 32'h0);

    // Zero-wait streaming with Advance held high
    for (int k = 0; k < 8; k++) begin
      @(negedge CLK);
      chk("stream_valid", {31'd0, InstrValid}, {31'd0, k[0]});
      if (!k[0]) begin
        chk("stream_req", {31'd0, IMemReq}, 32'd1);
        chk("stream_addr", IMemAddr, 32'(2 * k));
      end else begin
        exp_retire++;
      end
      if (k == 7) mem_wait = tbl[0].wait_cyc;
    end
    @(negedge CLK);
    Advance = 1'b0;
    chk("stream_retire", RetireCount, 32'd4);

    // Vector table: fetch with wait states, hold, then redirect
    for (int i = 0; i < 7; i++) begin
      chk("vec_fetch_req", {31'd0, IMemReq}, 32'd1);
      chk("vec_fetch_addr", IMemAddr, tbl[i].pc);
      chk("vec_fetch_pc", PC, tbl[i].pc);
      held = Instr;
      n = 0;
      while (!InstrValid && n < 20) begin
        chk("vec_instr_before_ack", Instr, held);
        @(negedge CLK);
        n++;
      end
      chk("vec_wait_cycles", 32'(n), 32'(tbl[i].wait_cyc + 1));
      chk("vec_hold_req", {31'd0, IMemReq}, 32'd0);
      chk("vec_pcplus4", PCPlus4, tbl[i].pc + 32'd4);
      junk_ack = 1'b1;
      for (int h = 0; h < tbl[i].hold; h++) begin
        Advance  = 1'b0;
        PCSrc    = $urandom_range(0, 1);
        PCTarget = $urandom;
        @(negedge CLK);
        chk("hold_pc", PC, tbl[i].pc);
        chk("hold_instr", Instr, mem_data(tbl[i].pc));
        chk("hold_valid", {31'd0, InstrValid}, 32'd1);
        chk("hold_req", {31'd0, IMemReq}, 32'd0);
      end
      junk_ack = 1'b0;
      Advance  = 1'b1;
      PCSrc    = tbl[i].pcsrc;
      PCTarget = tbl[i].tgt;
      exp_retire++;
      if (i + 1 < 7) mem_wait = tbl[i + 1].wait_cyc;
      @(negedge CLK);
      Advance = 1'b0;
      chk("vec_valid_after", {31'd0, InstrValid}, 32'd0);
      chk("vec_fault", {31'd0, Fault}, {31'd0, tbl[i].exp_fault});
      chk("vec_retire", RetireCount, 32'(exp_retire));
      if (tbl[i].exp_fault) begin
        chk("vec_fault_pc", PC, tbl[i].exp_next);
        chk("vec_fault_req", {31'd0, IMemReq}, 32'd0);
      end else begin
        chk("vec_next_req", {31'd0, IMemReq}, 32'd1);
        chk("vec_next_addr", IMemAddr, tbl[i].exp_next);
        chk("vec_next_pcplus4", PCPlus4, tbl[i].exp_next + 32'd4);
      end
    end

    // Fault is sticky and ignores every input
    junk_ack = 1'b1;
    for (int f = 0; f < 6; f++) begin
      Advance  = 1'b1;
      PCSrc    = $urandom_range(0, 1);
      PCTarget = {$urandom, 2'b00} >> 2;
      @(negedge CLK);
      chk("fault_sticky", {31'd0, Fault}, 32'd1);
      chk("fault_req", {31'd0, IMemReq}, 32'd0);
      chk("fault_valid", {31'd0, InstrValid}, 32'd0);
      chk("fault_pc", PC, 32'h40);
      chk("fault_retire", RetireCount, 32'(exp_retire));
    end
    junk_ack = 1'b0;
    Advance  = 1'b0;

    // Reset pulse clears the trap
    @(posedge CLK); #2 RST = 1'b0;
    #1;
    chk("fault_rst_pc", PC, RST_PC);
    chk("fault_rst_fault", {31'd0, Fault}, 32'd0);
    chk("fault_rst_retire", RetireCount, 32'd0);
    @(negedge CLK); #2 RST = 1'b1;
    Advance = 1'b1; PCSrc = 1'b0; mem_wait = 0;
    #1;
    chk("rerun_req", {31'd0, IMemReq}, 32'd1);
    @(negedge CLK);
    @(negedge CLK);
    chk("rerun_valid", {31'd0, InstrValid}, 32'd1);
    mem_wait = 50;
    @(negedge CLK);
    Advance = 1'b0;
    chk("async_pre_req", {31'd0, IMemReq}, 32'd1);
    chk("async_pre_addr", IMemAddr, 32'h4);

    // Asynchronous reset between edges aborts the fetch at once
    @(posedge CLK); #2 RST = 1'b0;
    #1;
    chk("async_req", {31'd0, IMemReq}, 32'd0);
    chk("async_pc", PC, RST_PC);
    chk("async_valid", {31'd0, InstrValid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
